count_expand_3to6: RTL and testbench
====================================

COUNT_EXPAND_3TO6 -- requirements
Module: count_expand_3to6

Interface
REQ-001 SHALL have parameter DEPTH, default 2, output buffer depth in entries (legal 2..8, power of two).
REQ-002 SHALL have parameter MSB_FIRST, default 0, mask fill order (0: fill from bit 0 upward; 1: fill from bit 5 downward).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  in_count valid.
REQ-006 SHALL have port in_ready  output  1  block accepts in_count this cycle.
REQ-007 SHALL have port in_count  input  3  weighted compressor result {cout,carry,sum} = 4/2/1, legal 0..6.
REQ-008 SHALL have port out_valid  output  1  out_mask valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts out_mask.
REQ-010 SHALL have port out_mask  output  6  thermometer-coded expansion of the count.
REQ-011 SHALL have port err_illegal  output  1  sticky flag, illegal count 7 accepted.
REQ-012 SHALL have port err_clr  input  1  clears err_illegal.
REQ-013 SHALL have port ones_total  output  16  running sum of set bits over all delivered masks.

Function
REQ-014 SHALL accept an input on cycle with in_valid && in_ready; output handshake on out_valid && out_ready.
REQ-015 SHALL expand count N (0..6) to a mask with exactly N bits set, contiguous from bit 0 (MSB_FIRST=0) or bit 5 (MSB_FIRST=1).
REQ-016 SHALL map illegal count 7 to mask 6'b111111 and set err_illegal on the following edge.
REQ-017 SHALL store expanded masks in a DEPTH-entry FIFO; out_mask/out_valid SHALL be driven from the FIFO head register only (no combinational in->out path).
REQ-018 SHALL present out_valid the cycle after accepting into an empty FIFO (latency 1).
REQ-019 SHALL drive in_ready = FIFO not full, registered-state only; in_ready SHALL NOT depend on out_ready.
REQ-020 SHALL, on simultaneous accept and deliver with FIFO non-empty and non-full, keep occupancy unchanged and preserve order.
REQ-021 SHALL, when FIFO is full and a deliver occurs, deassert nothing else; in_ready rises the next cycle.
REQ-022 SHALL hold out_mask stable while out_valid && !out_ready.
REQ-023 SHALL, on each delivery, add popcount(out_mask) (0..6) to ones_total, wrapping modulo 2^16.
REQ-024 SHALL clear err_illegal when err_clr=1 unless an illegal count is accepted the same cycle (set wins).
REQ-025 SHALL ignore in_count when in_valid=0 and SHALL treat X-free in_count only.

Reset
REQ-026 SHALL, with rst=1 at a rising edge, empty the FIFO, set out_valid=0, out_mask=0, err_illegal=0, ones_total=0, in_ready=0 during reset.
REQ-027 SHALL assert in_ready=1 the first cycle after rst deasserts.
REQ-028 SHALL discard any buffered or in-flight entries on reset mid-stream; no partial delivery afterward.
REQ-029 SHALL give rst priority over err_clr and all handshakes.

Structure
REQ-030 SHALL place in a shared package: count width 3, mask width 6, total width 16, illegal code 3'd7, and a pure function mapping count to thermometer mask for each fill order.
REQ-031 SHALL implement the buffer as one sub-module mask_fifo (synchronous, parameterized width/depth, full/empty flags, registered head).
REQ-032 SHALL compute popcount for ones_total from the delivered mask, not from the stored count.

Verification
REQ-033 SHALL cover: after reset, in_count=3 accepted, out_ready=1 -> next cycle out_valid=1, out_mask=6'b000111, ones_total=3 one cycle later.
REQ-034 SHALL cover: MSB_FIRST=1, counts 0,1,6 back-to-back -> masks 6'b000000, 6'b100000, 6'b111111 in order, ones_total=7.
REQ-035 SHALL cover: out_ready=0, three inputs offered (DEPTH=2) -> two accepted, in_ready=0, out_mask held; release -> third accepted next cycle, order preserved.
REQ-036 SHALL cover: in_count=7 accepted -> out_mask=6'b111111, err_illegal=1; err_clr pulse with concurrent in_count=7 -> err_illegal stays 1; lone err_clr -> 0.
REQ-037 SHALL cover: 10923 deliveries of count 6 -> ones_total wraps to (65538 mod 65536)=2.
REQ-038 SHALL cover: rst asserted with FIFO full -> next cycle out_valid=0, ones_total=0, in_ready=1 after release.

Source files
------------

// File: rtl/count_expand_3to6_pkg.sv
// Shared widths, codes and helpers for the 3-bit count to 6-bit thermometer expander.
// Latency: none (pure definitions and combinational functions).
// Backpressure: not applicable.
package count_expand_3to6_pkg;

    localparam int CNT_W   = 3;
    localparam int MASK_W  = 6;
    localparam int TOTAL_W = 16;

    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [MASK_W-1:0]  mask_t;
    typedef logic [TOTAL_W-1:0] total_t;

    localparam cnt_t CNT_ILLEGAL = 3'd7;

    typedef enum logic {
        FILL_LSB = 1'b0,
        FILL_MSB = 1'b1
    } fill_order_e;

    // Thermometer expansion: cnt bits set, packed against bit 0 or bit 5.
    // Count 7 compares true for every bit position, so it saturates to all ones.
    function automatic mask_t therm_mask(input cnt_t cnt, input logic msb_first);
        mask_t m;
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (msb_first) begin
                m[MASK_W-1-i] = (i < int'(cnt));
            end else begin
                m[i] = (i < int'(cnt));
            end
        end
        return m;
    endfunction

    // Number of set bits in a mask (0..6 fits in 3 bits).
    function automatic cnt_t popcount(input mask_t m);
        cnt_t n;
        n = '0;
        for (int i = 0; i < MASK_W; i++) begin
            n = n + cnt_t'(m[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/count_expand_3to6_if.sv
// Handshake bundle for the count expander: input count stream, output mask stream, status.
// Latency: none (wires only).
// Backpressure: valid/ready on both streams; in_ready is independent of out_ready.
interface count_expand_3to6_if;
    import count_expand_3to6_pkg::*;

    logic   in_valid;
    logic   in_ready;
    cnt_t   in_count;
    logic   out_valid;
    logic   out_ready;
    mask_t  out_mask;
    logic   err_illegal;
    logic   err_clr;
    total_t ones_total;

    // Producer/consumer side (drives counts, accepts masks).
    modport master (
        output in_valid, in_count, out_ready, err_clr,
        input  in_ready, out_valid, out_mask, err_illegal, ones_total
    );

    // Expander side.
    modport slave (
        input  in_valid, in_count, out_ready, err_clr,
        output in_ready, out_valid, out_mask, err_illegal, ones_total
    );
endinterface

// File: rtl/count_expand_3to6_mask_fifo.sv
// Synchronous DEPTH-entry FIFO with full/empty flags; head read straight from storage registers.
// Latency: 1 cycle from push into an empty FIFO to head valid.
// Backpressure: caller must not push when full or pop when empty.
module mask_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_dat_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    wr_q;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;

    // Occupancy follows push/pop; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage and pointers; reset also zeroes storage so the head reads 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= push_dat_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop_i) begin
                rd_q <= rd_q + AW'(1);
            end
            cnt_q <= cnt_d;
        end
    end

    assign full_o     = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign head_dat_o = mem_q[rd_q];
endmodule

// File: rtl/count_expand_3to6.sv
// Expands a 0..6 compressor count into a thermometer mask, buffered through a small FIFO.
// Latency: 1 cycle from accept into an empty buffer to out_valid.
// Backpressure: in_ready = buffer not full (and not in reset); never looks at out_ready.
module count_expand_3to6
    import count_expand_3to6_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    count_expand_3to6_if.slave bus
);
    logic   accept;
    logic   deliver;
    logic   fifo_full;
    logic   fifo_empty;
    mask_t  head_mask;
    mask_t  in_mask;
    logic   err_q;
    logic   err_d;
    total_t total_q;
    total_t total_d;

    assign in_mask = therm_mask(bus.in_count, MSB_FIRST);
    assign accept  = bus.in_valid && bus.in_ready;
    assign deliver = bus.out_valid && bus.out_ready;

    mask_fifo #(
        .WIDTH (MASK_W),
        .DEPTH (DEPTH)
    ) u_mask_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (accept),
        .push_dat_i (in_mask),
        .pop_i      (deliver),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_dat_o (head_mask)
    );

    // Sticky illegal flag (a new illegal accept beats a clear) and running set-bit total.
    always_comb begin
        err_d   = err_q;
        total_d = total_q;
        if (accept && (bus.in_count == CNT_ILLEGAL)) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end
        if (deliver) begin
            total_d = total_q + total_t'(popcount(head_mask));
        end
    end

    // Status registers; reset wins over clear and handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q   <= 1'b0;
            total_q <= '0;
        end else begin
            err_q   <= err_d;
            total_q <= total_d;
        end
    end

    assign bus.in_ready    = !fifo_full && !rst;
    assign bus.out_valid   = !fifo_empty;
    assign bus.out_mask    = head_mask;
    assign bus.err_illegal = err_q;
    assign bus.ones_total  = total_q;
endmodule

// File: tb/tb_count_expand_3to6.sv
// Bench for count_expand_3to6: an LSB-first and an MSB-first instance share one stimulus stream.
// Latency: not applicable.
// Backpressure: out_ready driven by the bench, directed and random.
module tb_count_expand_3to6;
    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] in_count = 3'd0;
    logic       out_ready = 1'b0;
    logic       err_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    count_expand_3to6_if bus0 ();
    count_expand_3to6_if bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_count  = in_count;
    assign bus0.out_ready = out_ready;
    assign bus0.err_clr   = err_clr;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_count  = in_count;
    assign bus1.out_ready = out_ready;
    assign bus1.err_clr   = err_clr;

    count_expand_3to6 #(.DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_lsb (
        .clk (clk), .rst (rst), .bus (bus0)
    );
    count_expand_3to6 #(.DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut_msb (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference mask from plain arithmetic: n low ones, or n high ones of a 6-bit field.
    function automatic logic [5:0] ref_mask(input int c, input bit msb);
        int n;
        n = (c > 6) ? 6 : c;
        if (msb) return 6'(64 - (64 >> n));
        return 6'((1 << n) - 1);
    endfunction

    // Behavioural model: queue of accepted counts, sticky error, wrapping total.
    logic [2:0]  mq[$];
    logic        m_err = 1'b0;
    logic [15:0] m_total = 16'd0;
    bit          started = 1'b0;

    always @(posedge clk) begin
        bit acc, del;
        if (rst) begin
            mq.delete();
            m_err   = 1'b0;
            m_total = 16'd0;
            started = 1'b1;
        end else if (started) begin
            acc = in_valid && (mq.size() < DEPTH);
            del = (mq.size() > 0) && out_ready;
            if (del) begin
                m_total = m_total + 16'((mq[0] > 3'd6) ? 6 : int'(mq[0]));
                void'(mq.pop_front());
            end
            if (acc) mq.push_back(in_count);
            if (acc && in_count == 3'd7) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready_lsb", bus0.in_ready, (!rst && mq.size() < DEPTH));
            chk("in_ready_msb", bus1.in_ready, (!rst && mq.size() < DEPTH));
            chk("out_valid_lsb", bus0.out_valid, (mq.size() != 0));
            chk("out_valid_msb", bus1.out_valid, (mq.size() != 0));
            if (mq.size() != 0) begin
                chk("out_mask_lsb", bus0.out_mask, ref_mask(int'(mq[0]), 1'b0));
                chk("out_mask_msb", bus1.out_mask, ref_mask(int'(mq[0]), 1'b1));
            end
            chk("err_lsb", bus0.err_illegal, m_err);
            chk("err_msb", bus1.err_illegal, m_err);
            chk("total_lsb", bus0.ones_total, m_total);
            chk("total_msb", bus1.ones_total, m_total);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_count = 3'd0; out_ready = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    initial begin
        int n, guard;

        // Reset values, then one count of 3.
        idle();
        rst = 1'b1;
        step(); step();
        @(negedge clk);
        chk("rst_out_valid", bus0.out_valid, 1'b0);
        chk("rst_out_mask", bus0.out_mask, 6'd0);
        chk("rst_in_ready", bus0.in_ready, 1'b0);
        chk("rst_err", bus0.err_illegal, 1'b0);
        chk("rst_total", bus0.ones_total, 16'd0);
        step(); rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", bus0.in_ready, 1'b1);
        step(); in_valid = 1'b1; in_count = 3'd3; out_ready = 1'b1;
        step(); in_valid = 1'b0;
        @(negedge clk);
        chk("c3_valid", bus0.out_valid, 1'b1);
        chk("c3_mask_lsb", bus0.out_mask, 6'b000111);
        chk("c3_mask_msb", bus1.out_mask, 6'b111000);
        step();
        @(negedge clk);
        chk("c3_total", bus0.ones_total, 16'd3);

        // Counts 0,1,6 back-to-back on the MSB-first instance.
        do_reset();
        out_ready = 1'b1;
        step(); in_valid = 1'b1; in_count = 3'd0;
        step(); in_count = 3'd1;
        @(negedge clk); chk("msb_seq0", bus1.out_mask, 6'b000000);
        step(); in_count = 3'd6;
        @(negedge clk); chk("msb_seq1", bus1.out_mask, 6'b100000);
        step(); in_valid = 1'b0;
        @(negedge clk); chk("msb_seq6", bus1.out_mask, 6'b111111);
        step();
        @(negedge clk); chk("msb_seq_total", bus1.ones_total, 16'd7);

        // Backpressure: fill, hold, release.
        do_reset();
        step(); in_valid = 1'b1; in_count = 3'd2;
        step(); in_count = 3'd4;
        step(); in_count = 3'd5;
        @(negedge clk);
        chk("full_in_ready", bus0.in_ready, 1'b0);
        chk("full_head", bus0.out_mask, 6'b000011);
        step();
        @(negedge clk);
        chk("hold_head", bus0.out_mask, 6'b000011);
        step(); out_ready = 1'b1;
        @(negedge clk);
        chk("full_ready_indep", bus0.in_ready, 1'b0);
        step();
        @(negedge clk);
        chk("release_in_ready", bus0.in_ready, 1'b1);
        chk("release_head", bus0.out_mask, 6'b001111);
        step(); in_valid = 1'b0;
        @(negedge clk);
        chk("third_head", bus0.out_mask, 6'b011111);
        step();
        @(negedge clk);
        chk("bp_total", bus0.ones_total, 16'd11);
        chk("bp_drained", bus0.out_valid, 1'b0);

        // Illegal count and sticky flag with clear.
        do_reset();
        out_ready = 1'b1;
        step(); in_valid = 1'b1; in_count = 3'd7;
        step(); in_valid = 1'b0;
        @(negedge clk);
        chk("ill_mask_lsb", bus0.out_mask, 6'b111111);
        chk("ill_mask_msb", bus1.out_mask, 6'b111111);
        chk("ill_err", bus0.err_illegal, 1'b1);
        step(); in_valid = 1'b1; in_count = 3'd7; err_clr = 1'b1;
        step(); in_valid = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        chk("ill_set_wins", bus0.err_illegal, 1'b1);
        step(); err_clr = 1'b1;
        step(); err_clr = 1'b0;
        @(negedge clk);
        chk("ill_cleared", bus0.err_illegal, 1'b0);

        // Total wrap: 10923 deliveries of 6.
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_count = 3'd6;
        n = 0; guard = 0;
        while (n < 10923 && guard < 20000) begin
            @(negedge clk);
            if (bus0.in_ready) n++;
            guard++;
            step();
        end
        chk("wrap_accepts", n, 10923);
        in_valid = 1'b0;
        step(); step();
        @(negedge clk);
        chk("wrap_total_lsb", bus0.ones_total, 16'd2);
        chk("wrap_total_msb", bus1.ones_total, 16'd2);

        // Reset with the buffer full.
        do_reset();
        step(); in_valid = 1'b1; in_count = 3'd1;
        step(); in_count = 3'd2;
        step(); in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_full", bus0.in_ready, 1'b0);
        step(); rst = 1'b1; out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("mid_rst_valid", bus0.out_valid, 1'b0);
        chk("mid_rst_total", bus0.ones_total, 16'd0);
        step(); rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", bus0.in_ready, 1'b1);
        step(); step();
        @(negedge clk);
        chk("post_rst_no_deliv", bus0.ones_total, 16'd0);

        // Random traffic with occasional reset and clear.
        for (int i = 0; i < 3000; i++) begin
            step();
            rst       = ($urandom_range(0, 199) == 0);
            in_valid  = $urandom_range(0, 1) == 1;
            in_count  = 3'($urandom_range(0, 7));
            out_ready = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            err_clr   = ($urandom_range(0, 15) == 0);
        end
        step(); idle();
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
